prefetch_issue_queue: RTL and testbench
=======================================

Name: prefetch_issue_queue

Overview:
- Sits between next_line_prefetcher and the memory-side port. Consumes the prefetcher's next-line addresses and queues them in a small FIFO with duplicate suppression.
- Issues queued addresses one at a time to memory over a req/ack handshake. Reports each completed fill back to the prefetch buffer as a one-cycle notification.
- Address-only (no data path), matching the without-data simulator build.

Parameters:
- block_size_byte, 16, cache line size in bytes; block_offset_index = log2(block_size_byte).
- depth, 4, FIFO entries; power of two, 2..16.
- cnt_width, 16, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pf_valid  input  1  prefetch request strobe, one request per high cycle.
- pf_address  input  32  requested prefetch address, any byte alignment.
- pf_ready  output  1  high when the queue is not full (registered count < depth).
- mem_req  output  1  memory request, held until acknowledged.
- mem_addr  output  32  line-aligned address of the outstanding request.
- mem_ack  input  1  memory completion, sampled only while mem_req=1.
- fill_valid  output  1  one-cycle pulse, line fetched.
- fill_address  output  32  line-aligned address of the completed fill, valid with fill_valid.
- queue_count  output  log2(depth)+1  number of queued entries, excluding the in-flight entry once popped.
- drop_count  output  cnt_width  saturating count of discarded requests.

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and count = 0; all entry valid bits = 0; FSM = IDLE.
  - mem_req=0, mem_addr=0, fill_valid=0, fill_address=0, drop_count=0, pf_ready=1.
- Line alignment:
  - line = {pf_address[31:block_offset_index], block_offset_index zeros}.
  - No wrap special case: 0xFFFFFFF0 is a legal line.
- Enqueue (cycle N, pf_valid=1), evaluated in this order:
  - Full (count==depth): drop; drop_count+1 (saturating at all-ones).
  - Duplicate: line equals any valid queued entry, or equals mem_addr while FSM != IDLE. Drop; drop_count+1.
  - Otherwise: write line at tail; count+1 at edge N; visible in queue_count at N+1.
- FSM (IDLE, REQ, FILL):
  - IDLE: if count>0, load head into mem_addr and set mem_req=1 at the edge; go to REQ. Otherwise stay in IDLE.
  - REQ: mem_req and mem_addr held stable. On mem_ack=1 at an edge:
    - mem_req <= 0; pop head (count-1, entry invalidated); go to FILL.
    - fill_valid <= 1 and fill_address <= mem_addr on the same edge.
  - FILL: fill_valid high for exactly this one cycle; next edge fill_valid <= 0 and FSM <= IDLE. mem_addr retains its value (used for duplicate check until IDLE).
- Latency:
  - Enqueue into an empty idle queue at edge N gives mem_req=1 after edge N+1.
  - mem_ack at edge M gives fill_valid high during cycle M..M+1.
  - Minimum 3 cycles per entry.
- Simultaneous events:
  - Enqueue and pop in the same edge: both happen; count unchanged.
  - pf_valid while full in the same cycle as a pop: still dropped, because pf_ready and the full test use the registered count.
  - mem_ack outside REQ: ignored.
- Ordering: strict FIFO; exactly one outstanding memory request at a time.
- Reset mid-transaction: the outstanding request is abandoned and mem_req drops immediately. No fill_valid is emitted for it.

Test Plan:
- Single request: pf_valid=1, pf_address=0x0000_1234 at edge 1 -> queue_count=1; mem_req=1, mem_addr=0x0000_1230 after edge 2; mem_ack at edge 5 -> fill_valid=1, fill_address=0x0000_1230 for one cycle; queue_count=0; mem_req=0.
- Duplicate drop: enqueue 0x100, then 0x10C while 0x100 is queued, then 0x104 while 0x100 is in flight -> single memory request 0x100; drop_count=2.
- Full: depth=4, mem_ack held low, enqueue 0x00,0x10,0x20,0x30,0x40,0x50 -> pf_ready=0 after 4th; drop_count=2; order of mem_addr after acks = 0x00,0x10,0x20,0x30.
- Simultaneous enqueue and pop: queue holds 2 entries, pf_valid=0x200 at the mem_ack edge -> queue_count stays 2; 0x200 served last.
- Async reset mid-REQ: mem_req=1 for 0x300, assert rst between edges -> mem_req, queue_count and drop_count go to 0 immediately, before the next edge; no fill_valid after release.
- Wrap/saturation: pf_address=0xFFFF_FFFF -> mem_addr=0xFFFF_FFF0. With cnt_width=2, 5 drops -> drop_count=3.

Source files
------------

// File: rtl/prefetch_issue_queue_if.sv
// ---------------------------------------------------------------------------
// prefetch_issue_queue_if
// Bundles the three sides of the prefetch issue queue:
//   prefetcher side : pf_valid, pf_address (into queue), pf_ready (out)
//   memory side     : mem_req, mem_addr (out), mem_ack (in)
//   fill notify     : fill_valid, fill_address (out)
//   status          : queue_count, drop_count (out)
// Modports:
//   slave  - the queue itself
//   master - the surrounding environment (prefetcher + memory + observers)
// ---------------------------------------------------------------------------
interface prefetch_issue_queue_if #(
  parameter int depth     = 4,
  parameter int cnt_width = 16
);
  localparam int count_width = $clog2(depth) + 1;

  logic                   pf_valid;
  logic [31:0]            pf_address;
  logic                   pf_ready;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_ack;
  logic                   fill_valid;
  logic [31:0]            fill_address;
  logic [count_width-1:0] queue_count;
  logic [cnt_width-1:0]   drop_count;

  modport slave (
    input  pf_valid, pf_address, mem_ack,
    output pf_ready, mem_req, mem_addr, fill_valid, fill_address,
           queue_count, drop_count
  );

  modport master (
    output pf_valid, pf_address, mem_ack,
    input  pf_ready, mem_req, mem_addr, fill_valid, fill_address,
           queue_count, drop_count
  );
endinterface

// File: rtl/prefetch_issue_queue.sv
// ---------------------------------------------------------------------------
// prefetch_issue_queue
// Queues next-line prefetch addresses in a small FIFO, suppresses duplicate
// lines, and issues them one at a time to memory over a req/ack handshake.
// Every completed fill is reported as a one-cycle fill_valid pulse.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - prefetch_issue_queue_if.slave (prefetch in, memory req/ack,
//          fill notify, queue_count / drop_count status)
// The depth and cnt_width parameters must match the connected interface.
// ---------------------------------------------------------------------------
module prefetch_issue_queue #(
  parameter int block_size_byte = 16,
  parameter int depth           = 4,
  parameter int cnt_width       = 16
) (
  input logic                   clk,
  input logic                   rst,
  prefetch_issue_queue_if.slave bus
);

  localparam int block_offset_index = $clog2(block_size_byte);
  localparam int ptr_width          = $clog2(depth);
  localparam int count_width        = ptr_width + 1;
  localparam logic [count_width-1:0] full_level = count_width'(depth);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            line_q [depth];
  logic [depth-1:0]       valid_q;
  logic [ptr_width-1:0]   head_q, tail_q;
  logic [count_width-1:0] count_q;
  logic [31:0]            mem_addr_q;
  logic [cnt_width-1:0]   drop_q;

  logic [31:0] pf_line;
  logic        unused_offset_bits;
  logic        dup_hit;
  logic        full;
  logic        enq;
  logic        drop;
  logic        pop;
  logic        issue;

  assign pf_line            = {bus.pf_address[31:block_offset_index], {block_offset_index{1'b0}}};
  assign unused_offset_bits = ^bus.pf_address[block_offset_index-1:0];

  // A line is a duplicate if it is still waiting in the queue, or if it is
  // the one currently being fetched (mem_addr stays meaningful until IDLE).
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (valid_q[i] && (line_q[i] == pf_line)) begin
        dup_hit = 1'b1;
      end
    end
    if ((state_q != IDLE) && (mem_addr_q == pf_line)) begin
      dup_hit = 1'b1;
    end
  end

  // Full is judged on the registered count, so a pop in the same cycle does
  // not rescue a request that arrives while full.
  assign full  = (count_q == full_level);
  assign enq   = bus.pf_valid && !full && !dup_hit;
  assign drop  = bus.pf_valid && (full || dup_hit);
  assign pop   = (state_q == REQ) && bus.mem_ack;
  assign issue = (state_q == IDLE) && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ:     if (bus.mem_ack)   state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs follow directly from the registered state, so they
  // change only at clock edges and drop at once on reset.
  always_comb begin
    bus.mem_req      = (state_q == REQ);
    bus.mem_addr     = mem_addr_q;
    bus.fill_valid   = (state_q == FILL);
    bus.fill_address = (state_q == FILL) ? mem_addr_q : 32'h0;
    bus.pf_ready     = !full;
    bus.queue_count  = count_q;
    bus.drop_count   = drop_q;
  end

  // Entry payloads need no reset; only their valid bits carry meaning.
  always_ff @(posedge clk) begin
    if (enq) begin
      line_q[tail_q] <= pf_line;
    end
  end

  // Queue bookkeeping. The head entry stays queued (and counted) while its
  // request is outstanding and is only retired on the acknowledge. Enqueue
  // and pop never target the same slot: a pop implies count >= 1 and an
  // enqueue implies count < depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      drop_q     <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + ptr_width'(1);
      end
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + ptr_width'(1);
      end
      case ({enq, pop})
        2'b10:   count_q <= count_q + count_width'(1);
        2'b01:   count_q <= count_q - count_width'(1);
        default: count_q <= count_q;
      endcase
      if (issue) begin
        mem_addr_q <= line_q[head_q];
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + cnt_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_prefetch_issue_queue
// Directed bench for prefetch_issue_queue. Instance dut_a uses the default
// parameters; instance dut_b uses cnt_width=2 to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_prefetch_issue_queue;

  logic clk;
  logic rst;

  int vec_count;
  int err_count;

  prefetch_issue_queue_if #(.depth(4), .cnt_width(16)) if_a ();
  prefetch_issue_queue_if #(.depth(4), .cnt_width(2))  if_b ();

  prefetch_issue_queue #(.block_size_byte(16), .depth(4), .cnt_width(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  prefetch_issue_queue #(.block_size_byte(16), .depth(4), .cnt_width(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a loop ever runs away.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic ack);
    if_a.pf_valid   = valid;
    if_a.pf_address = addr;
    if_a.mem_ack    = ack;
  endtask

  // Advance one edge and land 1 time unit after it, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until a fill pulse appears (bounded), then check its address.
  task automatic expectFill(input string tag, input logic [31:0] addr);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      step();
      if (if_a.fill_valid) found = 1'b1;
    end
    checkOutput({tag, "_seen"}, 32'(found), 32'd1);
    if (found) checkOutput({tag, "_addr"}, if_a.fill_address, addr);
  endtask

  initial begin
    int pulses;
    vec_count = 0;
    err_count = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    if_b.pf_valid   = 1'b0;
    if_b.pf_address = 32'h0;
    if_b.mem_ack    = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_mem_req",    32'(if_a.mem_req),      32'd0);
    checkOutput("rst_mem_addr",   if_a.mem_addr,          32'h0);
    checkOutput("rst_fill_valid", 32'(if_a.fill_valid),   32'd0);
    checkOutput("rst_fill_addr",  if_a.fill_address,      32'h0);
    checkOutput("rst_drop",       32'(if_a.drop_count),   32'd0);
    checkOutput("rst_pf_ready",   32'(if_a.pf_ready),     32'd1);
    checkOutput("rst_qcount",     32'(if_a.queue_count),  32'd0);

    // Single request
    applyStimulus(1'b1, 32'h0000_1234, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("single_qcount_n1", 32'(if_a.queue_count), 32'd1);
    checkOutput("single_req_n1",    32'(if_a.mem_req),     32'd0);
    step();
    checkOutput("single_req_n2",  32'(if_a.mem_req), 32'd1);
    checkOutput("single_addr_n2", if_a.mem_addr,     32'h0000_1230);
    step();
    step();
    checkOutput("single_req_held", 32'(if_a.mem_req), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("single_fill_valid", 32'(if_a.fill_valid),  32'd1);
    checkOutput("single_fill_addr",  if_a.fill_address,     32'h0000_1230);
    checkOutput("single_qcount_ack", 32'(if_a.queue_count), 32'd0);
    checkOutput("single_req_ack",    32'(if_a.mem_req),     32'd0);
    step();
    checkOutput("single_fill_pulse", 32'(if_a.fill_valid), 32'd0);

    // Duplicate drop: one queued, one in flight
    applyStimulus(1'b1, 32'h0000_0100, 1'b0);
    step();
    applyStimulus(1'b1, 32'h0000_010C, 1'b0);
    step();
    checkOutput("dup_queued_drop", 32'(if_a.drop_count),  32'd1);
    checkOutput("dup_qcount",      32'(if_a.queue_count), 32'd1);
    checkOutput("dup_req_addr",    if_a.mem_addr,         32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("dup_fill_addr", if_a.fill_address, 32'h0000_0100);
    applyStimulus(1'b1, 32'h0000_0104, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("dup_flight_drop", 32'(if_a.drop_count),  32'd2);
    checkOutput("dup_flight_qcnt", 32'(if_a.queue_count), 32'd0);
    step();
    step();
    checkOutput("dup_no_second_req", 32'(if_a.mem_req), 32'd0);

    // Full queue with acks held off
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'(i * 16), 1'b0);
      step();
      if (i == 3) begin
        checkOutput("full_pf_ready", 32'(if_a.pf_ready),    32'd0);
        checkOutput("full_qcount",   32'(if_a.queue_count), 32'd4);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("full_drop",    32'(if_a.drop_count),  32'd4);
    checkOutput("full_qcount2", 32'(if_a.queue_count), 32'd4);
    checkOutput("full_req",     32'(if_a.mem_req),     32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    expectFill("full_fill0", 32'h00);
    expectFill("full_fill1", 32'h10);
    expectFill("full_fill2", 32'h20);
    expectFill("full_fill3", 32'h30);
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    step();
    checkOutput("full_drained", 32'(if_a.queue_count), 32'd0);
    checkOutput("full_idle",    32'(if_a.mem_req),     32'd0);

    // Enqueue and pop on the same edge
    applyStimulus(1'b1, 32'h0000_0400, 1'b0);
    step();
    applyStimulus(1'b1, 32'h0000_0410, 1'b0);
    step();
    checkOutput("simul_qcount_pre", 32'(if_a.queue_count), 32'd2);
    checkOutput("simul_req_addr",   if_a.mem_addr,         32'h0000_0400);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("simul_qcount", 32'(if_a.queue_count), 32'd2);
    checkOutput("simul_fill0",  if_a.fill_address,     32'h0000_0400);
    expectFill("simul_fill1", 32'h0000_0410);
    expectFill("simul_fill2", 32'h0000_0200);
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    step();

    // Asynchronous reset while a request is outstanding
    applyStimulus(1'b1, 32'h0000_0300, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    checkOutput("arst_req_before",  32'(if_a.mem_req),    32'd1);
    checkOutput("arst_addr_before", if_a.mem_addr,        32'h0000_0300);
    checkOutput("arst_drop_before", 32'(if_a.drop_count), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_req",    32'(if_a.mem_req),     32'd0);
    checkOutput("arst_qcount", 32'(if_a.queue_count), 32'd0);
    checkOutput("arst_drop",   32'(if_a.drop_count),  32'd0);
    step();
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (if_a.fill_valid) pulses++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("arst_no_fill", 32'(pulses),        32'd0);
    checkOutput("arst_no_req",  32'(if_a.mem_req),  32'd0);

    // Top-of-memory line
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    checkOutput("wrap_req",  32'(if_a.mem_req), 32'd1);
    checkOutput("wrap_addr", if_a.mem_addr,     32'hFFFF_FFF0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_fill", if_a.fill_address, 32'hFFFF_FFF0);
    step();

    // Drop counter saturation on the 2-bit instance: 1 enqueue, 5 duplicates
    if_b.pf_valid   = 1'b1;
    if_b.pf_address = 32'h0000_0500;
    step();
    step();
    step();
    checkOutput("sat_drop2", 32'(if_b.drop_count), 32'd2);
    step();
    checkOutput("sat_drop3", 32'(if_b.drop_count), 32'd3);
    step();
    step();
    if_b.pf_valid = 1'b0;
    checkOutput("sat_hold", 32'(if_b.drop_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
